// File: rtl/bsg_nonce_dispatcher.sv
// bsg_nonce_dispatcher: splits a nonce range into chunks, deals them round-robin to cores, reports first hit
module bsg_nonce_dispatcher #(
  parameter int          num_cores_p  = 4,
  parameter logic [31:0] chunk_size_p = 32'h0001_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     job_v_i,
  output logic                     job_ready_o,
  input  logic [31:0]              job_start_i,
  input  logic [31:0]              job_end_i,
  input  logic [num_cores_p-1:0]   core_req_i,
  output logic [num_cores_p-1:0]   core_grant_o,
  output logic [31:0]              core_start_o,
  output logic [31:0]              core_limit_o,
  input  logic [num_cores_p-1:0]   core_found_i,
  input  logic [32*num_cores_p-1:0] core_found_nonce_i,
  output logic                     core_abort_o,
  output logic                     result_v_o,
  input  logic                     result_ready_i,
  output logic                     result_found_o,
  output logic [31:0]              result_nonce_o,
  output logic                     busy_o
);
  localparam int iw = num_cores_p > 1 ? $clog2(num_cores_p) : 1;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, REPORT} state_e;
  state_e state, state_n;
  logic [31:0] next_r, next_n, end_r, end_n, start_r, limit_r, nonce_r, nonce_n, hit_nonce, limit;
  logic [iw-1:0] rr, rr_n, gidx;
  logic [iw:0] sum_idx;
  logic [num_cores_p-1:0] outstanding, out_n, grant, hits;
  logic [2*num_cores_p-1:0] rot;
  logic [32:0] sum;
  logic found_r, found_n, abort_r, found_ev, req_hit;

  // round-robin pick, lowest-index hit winner, and chunk end clipped at 33 bits so it never wraps
  always_comb begin
    rot = {core_req_i, core_req_i} >> rr;
    req_hit = 1'b0;
    sum_idx = '0;
    for (int k = num_cores_p - 1; k >= 0; k--) if (rot[k]) begin
      req_hit = 1'b1;
      sum_idx = {1'b0, rr} + (iw+1)'(k);
    end
    gidx = sum_idx >= (iw+1)'(num_cores_p) ? iw'(sum_idx - (iw+1)'(num_cores_p)) : sum_idx[iw-1:0];
    hits = core_found_i & outstanding;
    hit_nonce = '0;
    for (int k = num_cores_p - 1; k >= 0; k--) if (hits[k]) hit_nonce = core_found_nonce_i[32*k +: 32];
    found_ev = (state == DISPATCH || state == DRAIN) && |hits;
    sum = {1'b0, next_r} + {1'b0, chunk_size_p};
    limit = sum > {1'b0, end_r} ? end_r : sum[31:0];
  end

  // next state, grant and datapath updates; a hit always wins over a grant
  always_comb begin
    state_n = state;
    next_n = next_r;
    end_n = end_r;
    rr_n = rr;
    found_n = found_r;
    nonce_n = nonce_r;
    grant = '0;
    case (state)
      IDLE: if (job_v_i) begin
        next_n = job_start_i;
        end_n = job_end_i;
        found_n = 1'b0;
        nonce_n = '0;
        state_n = job_start_i >= job_end_i ? REPORT : DISPATCH;
      end
      DISPATCH, DRAIN: if (found_ev) begin
        found_n = 1'b1;
        nonce_n = hit_nonce;
        state_n = REPORT;
      end else if (state == DISPATCH && req_hit) begin
        grant = num_cores_p'(1) << gidx;
        next_n = limit;
        rr_n = gidx == iw'(num_cores_p - 1) ? '0 : gidx + 1'b1;
        state_n = limit == end_r ? DRAIN : DISPATCH;
      end else if (state == DRAIN && outstanding == '0) begin
        state_n = REPORT;
      end
      default: if (result_ready_i) state_n = IDLE;
    endcase
    out_n = found_ev ? '0 : (outstanding & ~(core_req_i & ~grant)) | grant;
  end

  // state register
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else state <= state_n;

  // job, chunk, ownership and result registers
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      next_r <= '0;
      end_r <= '0;
      rr <= '0;
      outstanding <= '0;
      start_r <= '0;
      limit_r <= '0;
      found_r <= 1'b0;
      nonce_r <= '0;
      abort_r <= 1'b0;
    end else begin
      next_r <= next_n;
      end_r <= end_n;
      rr <= rr_n;
      outstanding <= out_n;
      start_r <= core_start_o;
      limit_r <= core_limit_o;
      found_r <= found_n;
      nonce_r <= nonce_n;
      abort_r <= found_ev;
    end

  assign job_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign result_v_o = state == REPORT;
  assign core_grant_o = grant;
  assign core_start_o = |grant ? next_r : start_r;
  assign core_limit_o = |grant ? limit : limit_r;
  assign core_abort_o = abort_r;
  assign result_found_o = found_r;
  assign result_nonce_o = nonce_r;
endmodule
